// File: rtl/fc_psum_drain.sv
// Deskews the staggered bottom-row psums of the FC systolic array into aligned vectors.
// Aligned vectors are buffered in a FIFO, handed off over valid/ready, and counted against num_vec.
module fc_psum_drain #(
  parameter int COLS  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CW-1:0]       num_vec,
  input  logic                psum_valid,
  input  logic [COLS*DW-1:0]  psum_i,
  output logic [COLS*DW-1:0]  out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic [CW-1:0]       vec_cnt,
  output logic                done
);

  localparam int AW = $clog2(DEPTH);

  logic [COLS*DW-1:0] aligned_data;
  logic               aligned_valid;
  logic [COLS-2:0]    vld_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= psum_valid;
      for (int i = 1; i < COLS-1; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign aligned_valid = vld_pipe[COLS-2];

  // Column c arrives c cycles after column 0, so it is delayed by COLS-1-c stages.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == COLS-1) begin : g_pass
      assign aligned_data[c*DW +: DW] = psum_i[c*DW +: DW];
    end else begin : g_dly
      localparam int N = COLS-1-c;
      logic [DW-1:0] dly [N];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) dly[i] <= '0;
        end else begin
          dly[0] <= psum_i[c*DW +: DW];
          for (int i = 1; i < N; i++) dly[i] <= dly[i-1];
        end
      end

      assign aligned_data[c*DW +: DW] = dly[N-1];
    end
  end

  logic [COLS*DW-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && out_ready;
  // A full FIFO still accepts a vector when the head leaves on the same edge.
  assign push  = aligned_valid && (!full || pop);
  assign drop  = aligned_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= aligned_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign out_valid = !empty;

  logic [CW-1:0] num_q;
  logic          armed_q;
  logic [CW-1:0] target;
  logic [CW-1:0] cnt_next;
  logic          armed;
  logic          done_d;

  // armed keeps done to a single firing between starts even if vec_cnt wraps.
  always_comb begin
    target   = num_q;
    armed    = armed_q;
    cnt_next = vec_cnt;
    if (start) begin
      target   = num_vec;
      armed    = 1'b1;
      cnt_next = pop ? CW'(1) : '0;
    end else if (pop) begin
      cnt_next = vec_cnt + CW'(1);
    end
    done_d = pop && armed && (target != '0) && (cnt_next == target);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_cnt  <= '0;
      done     <= 1'b0;
      num_q    <= '0;
      armed_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      vec_cnt <= cnt_next;
      done    <= done_d;
      num_q   <= target;
      armed_q <= armed && !done_d;
      if (start)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_psum_drain.sv
// Randomized scoreboard bench for fc_psum_drain against a vector-level reference model.
module tb_fc_psum_drain;

  localparam int COLS  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int VW    = COLS*DW;
  localparam int HN    = 8192;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_vec;
  logic          psum_valid;
  logic [VW-1:0] psum_i;
  logic [VW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;
  logic [CW-1:0] vec_cnt;
  logic          done;

  fc_psum_drain #(.COLS(COLS), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .psum_valid(psum_valid), .psum_i(psum_i), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .vec_cnt(vec_cnt), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            t;
    logic [VW-1:0] v;
  } pend_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  bit            mon_en = 0;
  logic          hist_v   [HN];
  logic [VW-1:0] hist_vec [HN];

  logic [VW-1:0] exp_q [$];
  pend_t         pend  [$];
  bit            m_pop = 0;
  bit            m_ovf = 0;
  bit            m_done = 0;
  bit            m_armed = 0;
  logic [CW-1:0] m_cnt = '0;
  logic [CW-1:0] m_num = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Column c of the vector launched at cycle t is driven at cycle t+c; unused lanes get noise.
  task automatic tick(input bit v, input logic [VW-1:0] vec, input bit rdy,
                      input bit st, input logic [CW-1:0] nv, input bit rn);
    hist_v[cyc % HN]   = v;
    hist_vec[cyc % HN] = vec;
    psum_valid = v;
    out_ready  = rdy;
    start      = st;
    num_vec    = nv;
    rst_n      = rn;
    for (int c = 0; c < COLS; c++) begin
      if (cyc >= c && hist_v[(cyc-c) % HN])
        psum_i[c*DW +: DW] = hist_vec[(cyc-c) % HN][c*DW +: DW];
      else
        psum_i[c*DW +: DW] = DW'($urandom);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, '0, rdy, 1'b0, '0, 1'b1);
  endtask

  // Monitor: compares what the DUT presents during the cycle and retires the head on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      chk("overflow",  64'(overflow),  64'(m_ovf));
      chk("vec_cnt",   64'(vec_cnt),   64'(m_cnt));
      chk("done",      64'(done),      64'(m_done));
      if (done) done_cnt++;
      if (exp_q.size() > 0 && out_ready) begin
        chk("out_data", 64'(out_data), 64'(exp_q[0]));
        void'(exp_q.pop_front());
        m_pop = 1;
      end
    end
  end

  // Reference model: a vector launched at t lands in the queue at the edge ending t+COLS-1.
  always @(posedge clk) begin
    bit drop;
    pend_t a;
    drop = 0;
    if (!rst_n) begin
      exp_q.delete();
      pend.delete();
      m_ovf = 0; m_done = 0; m_armed = 0; m_cnt = '0; m_num = '0;
    end else begin
      m_done = 0;
      if (pend.size() > 0 && pend[0].t == cyc) begin
        a = pend.pop_front();
        if (exp_q.size() < DEPTH) exp_q.push_back(a.v);
        else drop = 1;
      end
      if (start) begin
        m_ovf = 0; m_num = num_vec; m_armed = 1;
        m_cnt = m_pop ? CW'(1) : '0;
      end else begin
        if (drop) m_ovf = 1;
        if (m_pop) m_cnt = m_cnt + CW'(1);
      end
      if (m_pop && m_armed && m_num != '0 && m_cnt == m_num) begin
        m_done = 1;
        m_armed = 0;
      end
      if (psum_valid) pend.push_back('{cyc + COLS - 1, hist_vec[cyc % HN]});
    end
    m_pop = 0;
  end

  initial begin
    logic [VW-1:0] v;
    int d0;
    rst_n = 1'b0; start = 1'b0; num_vec = '0; psum_valid = 1'b0;
    psum_i = '0; out_ready = 1'b0;
    for (int i = 0; i < HN; i++) begin hist_v[i] = 1'b0; hist_vec[i] = '0; end

    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    mon_en = 1;
    chk("rst_out_data",  64'(out_data),  64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_vec_cnt",   64'(vec_cnt),   64'h0);

    // single vector
    for (int c = 0; c < COLS; c++) v[c*DW +: DW] = DW'(8'h10 + c);
    tick(1'b1, v, 1'b1, 1'b0, '0, 1'b1);
    idle(7, 1'b1);

    // back-to-back vectors
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < COLS; c++) v[c*DW +: DW] = DW'(16*k + c);
      tick(1'b1, v, 1'b1, 1'b0, '0, 1'b1);
    end
    idle(8, 1'b1);

    // backpressure with one dropped vector, then drain
    tick(1'b0, '0, 1'b0, 1'b1, '0, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b1, rand_vec(), 1'b0, 1'b0, '0, 1'b1);
    idle(8, 1'b0);
    chk("ovf_after_drop", 64'(overflow), 64'h1);
    chk("full_valid",     64'(out_valid), 64'h1);
    idle(8, 1'b1);

    // full FIFO with a pop on the cycle the next vector lands
    tick(1'b0, '0, 1'b0, 1'b1, '0, 1'b1);
    for (int k = 0; k < 4; k++) tick(1'b1, rand_vec(), 1'b0, 1'b0, '0, 1'b1);
    idle(5, 1'b0);
    tick(1'b1, rand_vec(), 1'b0, 1'b0, '0, 1'b1);
    idle(COLS-2, 1'b0);
    idle(1, 1'b1);
    idle(8, 1'b1);
    chk("no_ovf_on_pop", 64'(overflow), 64'h0);

    // done after 3 pops, none on the 4th
    d0 = done_cnt;
    tick(1'b0, '0, 1'b1, 1'b1, CW'(3), 1'b1);
    for (int k = 0; k < 4; k++) tick(1'b1, rand_vec(), 1'b1, 1'b0, '0, 1'b1);
    idle(8, 1'b1);
    chk("done_pulses", 64'(done_cnt - d0), 64'h1);
    chk("cnt_past_num", 64'(vec_cnt), 64'h4);

    // reset with entries in the FIFO and one vector in flight
    for (int k = 0; k < 2; k++) tick(1'b1, rand_vec(), 1'b0, 1'b0, '0, 1'b1);
    idle(6, 1'b0);
    tick(1'b1, rand_vec(), 1'b0, 1'b0, '0, 1'b1);
    idle(1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_mid_valid", 64'(out_valid), 64'h0);
    chk("rst_mid_ovf",   64'(overflow),  64'h0);
    chk("rst_mid_cnt",   64'(vec_cnt),   64'h0);
    idle(10, 1'b1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      tick($urandom_range(0, 99) < 55, rand_vec(), $urandom_range(0, 99) < 65,
           $urandom_range(0, 99) < 2, CW'($urandom_range(0, 12)),
           $urandom_range(0, 299) != 0);
    end
    idle(12, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
